tetris_piece_ctrl: RTL and testbench
====================================

// Module: tetris_piece_ctrl
// PURPOSE
//  Active-piece controller, directly upstream of the current-piece display stage. Holds falling piece
//  type/rotation/origin, applies move/rotate/drop/gravity requests after bounds + board-occupancy check,
//  and drives the four cell coordinates dot1..dot4 that the display stage renders. Pulses lock to the board stage.
// PARAMETERS
//  COLS       10  playfield width in cells (max 31)
//  ROWS       20  playfield height in cells (max 31)
//  SPAWN_COL  3   origin column of a newly spawned piece (origin row always 0)
// PORTS
//  clk          in   1          system clock
//  rst          in   1          synchronous, active-low reset
//  spawn        in   1          request new piece (honoured in IDLE only)
//  piece_type   in   3          0=I 1=O 2=T 3=S 4=Z 5=J 6=L; 7 treated as 0
//  cmd_left     in   1          move one column left
//  cmd_right    in   1          move one column right
//  cmd_rot      in   1          rotate clockwise
//  cmd_down     in   1          soft drop one row
//  grav_tick    in   1          gravity step (same action as cmd_down)
//  board_occ    in   COLS*ROWS  locked-cell map, bit index row*COLS+col
//  dot1..dot4   out  10 each    cell coords {col[9:5], row[4:0]}
//  piece_active out  1          piece present; dots valid
//  lock_pulse   out  1          1-cycle pulse: piece landed, dots hold final cells this cycle
//  game_over    out  1          spawn collided; sticky until reset
// BEHAVIOUR
//  - Reset (rst==0 at clk edge): state IDLE, dot1..dot4=0, piece_active=0, lock_pulse=0, game_over=0.
//  - States: IDLE, ACTIVE, CHECK, LOCK, OVER.
//  - IDLE: spawn=1 -> load type, rot=0, origin (SPAWN_COL,0) -> CHECK (spawn check).
//  - Spawn check: legal -> dots updated, piece_active=1, ACTIVE; illegal -> game_over=1, OVER (dots=0, piece_active=0).
//  - ACTIVE: one request accepted per cycle, priority cmd_rot > cmd_left > cmd_right > (cmd_down|grav_tick);
//    lower-priority requests that cycle are dropped. Accepted request -> candidate latched -> CHECK.
//  - CHECK: candidate legal iff every cell col<COLS, row<ROWS, board_occ bit clear. Legal -> commit
//    (dots change on the clock edge leaving CHECK) -> ACTIVE. Illegal left/right/rot -> discard -> ACTIVE.
//    Illegal down/gravity -> LOCK. Requests arriving in CHECK/LOCK are dropped, not queued.
//  - Latency: request seen in ACTIVE at cycle N -> dots updated at N+2.
//  - LOCK: lock_pulse=1 one cycle, dots hold final cells; next cycle piece_active=0, state IDLE.
//  - OVER: absorbing; only reset exits.
//  - Arithmetic: candidate col/row computed 6 bits wide; origin col 0 minus 1 = out of bounds (no wrap to 31).
//  - Shapes: offsets (x,y) added to origin, rot 0 in dot order:
//    I (0,1)(1,1)(2,1)(3,1); O (1,0)(2,0)(1,1)(2,1); T (1,0)(0,1)(1,1)(2,1); S (1,0)(2,0)(0,1)(1,1);
//    Z (0,0)(1,0)(1,1)(2,1); J (0,0)(0,1)(1,1)(2,1); L (2,0)(0,1)(1,1)(2,1).
//    Clockwise step: I (x,y)->(3-y,x); O unchanged; others (x,y)->(2-y,x). rot wraps 3->0.
//  - Dot order preserved through rotation (dotK = transformed Kth offset).
// CONFIGURATION
//  TETRIS_WALL_KICK_EN defined: illegal rotation retries candidate shifted col-1 (extra CHECK cycle),
//    then col+1 (another cycle); first legal one commits (latency N+3 / N+4); all illegal -> discard.
//  Not defined: illegal rotation discarded immediately; rotation latency always N+2.
// TESTING
//  1 Reset, empty board, spawn type 1 -> after 2 cycles dots = 128,160,129,161; piece_active=1.
//  2 O at origin col 0 (3 lefts from spawn), cmd_left -> dots unchanged; further cmd_right -> col+1.
//  3 O, empty board, 18 cmd_down -> origin row 18; 19th -> lock_pulse 1 cycle, then piece_active=0, IDLE.
//  4 board_occ bit 4 set, spawn type 1 -> game_over=1, piece_active=0; spawn ignored until reset.
//  5 cmd_rot+cmd_left same cycle on T -> rotation only applied, column unchanged.
//  6 rst low during CHECK -> all outputs 0 next edge; I at col 8 rot: kick macro on -> shifted commit, off -> discarded.

Source files
------------

// File: rtl/tetris_piece_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tetris_piece_ctrl
// Purpose  : Falling-piece controller. Checks moves against bounds and the board
//            and drives the four piece cells. Wall kick via TETRIS_WALL_KICK_EN.
// Revision : 1.0  initial release
// ============================================================================
module tetris_piece_ctrl #(
  parameter int COLS      = 10,
  parameter int ROWS      = 20,
  parameter int SPAWN_COL = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 spawn,
  input  logic [2:0]           piece_type,
  input  logic                 cmd_left,
  input  logic                 cmd_right,
  input  logic                 cmd_rot,
  input  logic                 cmd_down,
  input  logic                 grav_tick,
  input  logic [COLS*ROWS-1:0] board_occ,
  output logic [9:0]           dot1,
  output logic [9:0]           dot2,
  output logic [9:0]           dot3,
  output logic [9:0]           dot4,
  output logic                 piece_active,
  output logic                 lock_pulse,
  output logic                 game_over
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACTIVE = 3'd1,
    S_CHECK  = 3'd2,
    S_LOCK   = 3'd3,
    S_OVER   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    K_SPAWN = 2'd0,
    K_SHIFT = 2'd1,
    K_ROT   = 2'd2,
    K_DOWN  = 2'd3
  } kind_t;

  state_t      r_state, w_state_nxt;
  kind_t       r_kind, w_kind_nxt;
  logic [2:0]  r_type;
  logic [1:0]  r_rot, r_cand_rot, w_cand_rot_nxt;
  logic [5:0]  r_col, r_row, r_cand_col, r_cand_row, w_cand_col_nxt, w_cand_row_nxt;
  logic [9:0]  r_dot [4];
  logic        w_load_type, w_commit, w_clear_dots, w_legal;
  logic [6:0]  w_cx [4];
  logic [6:0]  w_cy [4];
  logic [3:0]  w_cell_ok;
  logic [10:0] w_idx;
  logic [3:0]  w_off;
  logic [COLS*ROWS-1:0] w_shift;
`ifdef TETRIS_WALL_KICK_EN
  logic [1:0]  r_kick, w_kick_nxt;
`endif

  // Offset {x,y} of dot k for a given type and rotation; clockwise steps applied iteratively
  function automatic logic [3:0] f_offset(input logic [2:0] t, input logic [1:0] rot, input int k);
    logic [15:0] shape;
    logic [1:0]  x, y, nx;
    case (t)
      3'd1:    shape = {2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd1, 2'd2, 2'd1};
      3'd2:    shape = {2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1};
      3'd3:    shape = {2'd1, 2'd0, 2'd2, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1};
      3'd4:    shape = {2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd1, 2'd2, 2'd1};
      3'd5:    shape = {2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1};
      3'd6:    shape = {2'd2, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1};
      default: shape = {2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1, 2'd3, 2'd1};
    endcase
    shape = shape >> (4 * (3 - k));
    x = shape[3:2];
    y = shape[1:0];
    for (int i = 0; i < 3; i++) begin
      if (2'(i) < rot) begin
        if (t == 3'd0 || t == 3'd7) begin
          nx = 2'd3 - y;
          y  = x;
          x  = nx;
        end else if (t != 3'd1) begin
          nx = 2'd2 - y;
          y  = x;
          x  = nx;
        end
      end
    end
    return {x, y};
  endfunction

  // Candidate cells use 7-bit math so a wrapped origin (0-1 = 63) stays out of bounds
  always_comb begin
    w_off   = '0;
    w_idx   = '0;
    w_shift = '0;
    for (int k = 0; k < 4; k++) begin
      w_off        = f_offset(r_type, r_cand_rot, k);
      w_cx[k]      = {1'b0, r_cand_col} + {5'd0, w_off[3:2]};
      w_cy[k]      = {1'b0, r_cand_row} + {5'd0, w_off[1:0]};
      w_idx        = 11'(w_cy[k]) * 11'(COLS) + 11'(w_cx[k]);
      w_shift      = board_occ >> w_idx;
      w_cell_ok[k] = (w_cx[k] < 7'(COLS)) && (w_cy[k] < 7'(ROWS)) && !w_shift[0];
    end
    w_legal = &w_cell_ok;
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_kind_nxt     = r_kind;
    w_cand_rot_nxt = r_cand_rot;
    w_cand_col_nxt = r_cand_col;
    w_cand_row_nxt = r_cand_row;
    w_load_type    = 1'b0;
    w_commit       = 1'b0;
    w_clear_dots   = 1'b0;
`ifdef TETRIS_WALL_KICK_EN
    w_kick_nxt     = r_kick;
`endif
    case (r_state)
      S_IDLE: begin
        if (spawn) begin
          w_load_type    = 1'b1;
          w_kind_nxt     = K_SPAWN;
          w_cand_rot_nxt = 2'd0;
          w_cand_col_nxt = 6'(SPAWN_COL);
          w_cand_row_nxt = 6'd0;
          w_state_nxt    = S_CHECK;
        end
      end
      S_ACTIVE: begin
        w_cand_rot_nxt = r_rot;
        w_cand_col_nxt = r_col;
        w_cand_row_nxt = r_row;
`ifdef TETRIS_WALL_KICK_EN
        w_kick_nxt     = 2'd0;
`endif
        if (cmd_rot) begin
          w_cand_rot_nxt = r_rot + 2'd1;
          w_kind_nxt     = K_ROT;
          w_state_nxt    = S_CHECK;
        end else if (cmd_left) begin
          w_cand_col_nxt = r_col - 6'd1;
          w_kind_nxt     = K_SHIFT;
          w_state_nxt    = S_CHECK;
        end else if (cmd_right) begin
          w_cand_col_nxt = r_col + 6'd1;
          w_kind_nxt     = K_SHIFT;
          w_state_nxt    = S_CHECK;
        end else if (cmd_down || grav_tick) begin
          w_cand_row_nxt = r_row + 6'd1;
          w_kind_nxt     = K_DOWN;
          w_state_nxt    = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_legal) begin
          w_commit    = 1'b1;
          w_state_nxt = S_ACTIVE;
        end else begin
          case (r_kind)
            K_SPAWN: w_state_nxt = S_OVER;
            K_DOWN:  w_state_nxt = S_LOCK;
`ifdef TETRIS_WALL_KICK_EN
            K_ROT: begin
              // Second retry is +2 from the first kick, i.e. original column + 1
              if (r_kick == 2'd0) begin
                w_cand_col_nxt = r_cand_col - 6'd1;
                w_kick_nxt     = 2'd1;
              end else if (r_kick == 2'd1) begin
                w_cand_col_nxt = r_cand_col + 6'd2;
                w_kick_nxt     = 2'd2;
              end else begin
                w_state_nxt    = S_ACTIVE;
              end
            end
`endif
            default: w_state_nxt = S_ACTIVE;
          endcase
        end
      end
      S_LOCK: begin
        w_clear_dots = 1'b1;
        w_state_nxt  = S_IDLE;
      end
      S_OVER:  w_state_nxt = S_OVER;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_kind     <= K_SPAWN;
      r_type     <= 3'd0;
      r_rot      <= 2'd0;
      r_col      <= 6'd0;
      r_row      <= 6'd0;
      r_cand_rot <= 2'd0;
      r_cand_col <= 6'd0;
      r_cand_row <= 6'd0;
      for (int k = 0; k < 4; k++) r_dot[k] <= 10'd0;
`ifdef TETRIS_WALL_KICK_EN
      r_kick     <= 2'd0;
`endif
    end else begin
      r_kind     <= w_kind_nxt;
      r_cand_rot <= w_cand_rot_nxt;
      r_cand_col <= w_cand_col_nxt;
      r_cand_row <= w_cand_row_nxt;
`ifdef TETRIS_WALL_KICK_EN
      r_kick     <= w_kick_nxt;
`endif
      if (w_load_type) r_type <= piece_type;
      if (w_commit) begin
        r_rot <= r_cand_rot;
        r_col <= r_cand_col;
        r_row <= r_cand_row;
        for (int k = 0; k < 4; k++) r_dot[k] <= {w_cx[k][4:0], w_cy[k][4:0]};
      end else if (w_clear_dots) begin
        for (int k = 0; k < 4; k++) r_dot[k] <= 10'd0;
      end
    end
  end

  always_comb begin
    piece_active = (r_state == S_ACTIVE) || (r_state == S_LOCK) ||
                   ((r_state == S_CHECK) && (r_kind != K_SPAWN));
    lock_pulse   = (r_state == S_LOCK);
    game_over    = (r_state == S_OVER);
  end

  assign dot1 = r_dot[0];
  assign dot2 = r_dot[1];
  assign dot3 = r_dot[2];
  assign dot4 = r_dot[3];

endmodule
`default_nettype wire

// File: tb/tb_tetris_piece_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tetris_piece_ctrl
// Purpose  : Directed self-checking bench for tetris_piece_ctrl (default 10x20).
// Revision : 1.0  initial release
// ============================================================================
module tb_tetris_piece_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         spawn;
  logic [2:0]   piece_type;
  logic         cmd_left, cmd_right, cmd_rot, cmd_down, grav_tick;
  logic [199:0] board_occ;
  logic [9:0]   dot1, dot2, dot3, dot4;
  logic         piece_active, lock_pulse, game_over;
  int           n_pass = 0;
  int           n_total = 0;

  tetris_piece_ctrl #(.COLS(10), .ROWS(20), .SPAWN_COL(3)) dut (
    .clk(clk), .rst(rst), .spawn(spawn), .piece_type(piece_type),
    .cmd_left(cmd_left), .cmd_right(cmd_right), .cmd_rot(cmd_rot),
    .cmd_down(cmd_down), .grav_tick(grav_tick), .board_occ(board_occ),
    .dot1(dot1), .dot2(dot2), .dot3(dot3), .dot4(dot4),
    .piece_active(piece_active), .lock_pulse(lock_pulse), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic chk_dots(input string tag, input int e1, input int e2, input int e3, input int e4);
    chk({tag, ".dot1"}, 32'(dot1), 32'(e1));
    chk({tag, ".dot2"}, 32'(dot2), 32'(e2));
    chk({tag, ".dot3"}, 32'(dot3), 32'(e3));
    chk({tag, ".dot4"}, 32'(dot4), 32'(e4));
  endtask

  // One-cycle request pulse {rot,left,right,down,grav}, returns after two edges
  task automatic cmd(input logic r, input logic l, input logic rt, input logic d, input logic g);
    cmd_rot = r; cmd_left = l; cmd_right = rt; cmd_down = d; grav_tick = g;
    tick();
    cmd_rot = 0; cmd_left = 0; cmd_right = 0; cmd_down = 0; grav_tick = 0;
    tick();
  endtask

  task automatic do_spawn(input logic [2:0] t);
    piece_type = t;
    spawn = 1'b1;
    tick();
    spawn = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst = 0; spawn = 0; piece_type = 0; board_occ = '0;
    cmd_left = 0; cmd_right = 0; cmd_rot = 0; cmd_down = 0; grav_tick = 0;
    tick();
    tick();
    chk_dots("reset", 0, 0, 0, 0);
    chk("reset.active", 32'(piece_active), 0);
    chk("reset.lock", 32'(lock_pulse), 0);
    chk("reset.over", 32'(game_over), 0);
    rst = 1'b1;
    tick();

    // O spawn at column 3
    do_spawn(3'd1);
    chk_dots("spawn_o", 128, 160, 129, 161);
    chk("spawn_o.active", 32'(piece_active), 1);

    // Left wall
    cmd(0, 1, 0, 0, 0);
    cmd(0, 1, 0, 0, 0);
    cmd(0, 1, 0, 0, 0);
    chk_dots("o_col0", 32, 64, 33, 65);
    cmd(0, 1, 0, 0, 0);
    chk_dots("o_left_wall", 32, 64, 33, 65);
    cmd(0, 0, 1, 0, 0);
    chk_dots("o_right", 64, 96, 65, 97);

    // Drop to the floor, mixing soft drop and gravity
    for (int i = 0; i < 18; i++) cmd(0, 0, 0, (i % 2) == 0, (i % 2) == 1);
    chk_dots("o_row18", 82, 114, 83, 115);
    chk("o_row18.active", 32'(piece_active), 1);
    cmd(0, 0, 0, 1, 0);
    chk("lock.pulse", 32'(lock_pulse), 1);
    chk("lock.dot1", 32'(dot1), 82);
    chk("lock.active", 32'(piece_active), 1);
    tick();
    chk("after_lock.pulse", 32'(lock_pulse), 0);
    chk("after_lock.active", 32'(piece_active), 0);
    do_spawn(3'd1);
    chk("respawn.dot1", 32'(dot1), 128);

    // Blocked spawn
    do_reset();
    board_occ[4] = 1'b1;
    do_spawn(3'd1);
    chk("over.flag", 32'(game_over), 1);
    chk("over.active", 32'(piece_active), 0);
    chk("over.dot1", 32'(dot1), 0);
    board_occ = '0;
    do_spawn(3'd1);
    chk("over_sticky.flag", 32'(game_over), 1);
    chk("over_sticky.active", 32'(piece_active), 0);

    // T: rotate beats left
    do_reset();
    do_spawn(3'd2);
    chk_dots("spawn_t", 128, 97, 129, 161);
    cmd(1, 1, 0, 0, 0);
    chk_dots("t_rot_prio", 161, 128, 129, 130);
    cmd(1, 0, 0, 0, 0);
    cmd(1, 0, 0, 0, 0);
    chk_dots("t_rot3", 97, 130, 129, 128);
    for (int i = 0; i < 5; i++) cmd(0, 0, 1, 0, 0);
    chk_dots("t_col8", 257, 290, 289, 288);
    cmd(0, 0, 1, 0, 0);
    chk_dots("t_right_wall", 257, 290, 289, 288);
    cmd(1, 0, 0, 0, 0);
    tick();
    tick();
`ifdef TETRIS_WALL_KICK_EN
    chk_dots("t_rot_wall", 256, 225, 257, 289);
`else
    chk_dots("t_rot_wall", 257, 290, 289, 288);
`endif

    // Reset while a candidate is being checked
    cmd_down = 1'b1;
    tick();
    cmd_down = 1'b0;
    rst = 1'b0;
    tick();
    chk_dots("rst_in_check", 0, 0, 0, 0);
    chk("rst_in_check.active", 32'(piece_active), 0);
    chk("rst_in_check.lock", 32'(lock_pulse), 0);
    chk("rst_in_check.over", 32'(game_over), 0);
    rst = 1'b1;
    tick();

    // Type 7 behaves as I; left beats right; down and gravity together move one row
    do_spawn(3'd7);
    chk_dots("spawn_i7", 97, 129, 161, 193);
    cmd(0, 1, 1, 0, 0);
    chk_dots("i_left_prio", 65, 97, 129, 161);
    cmd(0, 0, 0, 1, 1);
    chk_dots("i_down_grav", 66, 98, 130, 162);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
